// File: rtl/mcu_frame_router.sv
`default_nettype none
// ============================================================================
// Module      : mcu_frame_router
// Description : Routes MCU frames to one of NUM_TGT on-chip targets. The first
//               byte of a frame selects the target. The remaining bytes are
//               forwarded with a one-cycle latency, and the selected target's
//               response byte is muxed back to the MCU. A watchdog aborts
//               stalled frames, and a saturating counter records bad ids and
//               timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_frame_router #(
    parameter int         NUM_TGT     = 4,
    parameter int         TIMEOUT     = 50000,
    parameter logic [7:0] DEFAULT_RSP = 8'hFF,
    localparam int        SW          = $clog2(NUM_TGT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_strobe,
    input  logic                 in_start,
    input  logic [7:0]           in_data,
    output logic [7:0]           out_data,
    output logic [NUM_TGT-1:0]   tgt_strobe,
    output logic                 tgt_start,
    output logic [7:0]           tgt_data,
    input  logic [NUM_TGT*8-1:0] tgt_dout,
    output logic                 busy,
    output logic [SW-1:0]        sel,
    output logic [7:0]           err_count
);

    // Frame states: FIRST waits for the byte that carries tgt_start.
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_FIRST  = 2'd1;
    localparam logic [1:0] c_ST_STREAM = 2'd2;
    localparam logic [1:0] c_ST_DRAIN  = 2'd3;

    localparam int            c_WDW      = $clog2(TIMEOUT);
    localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TIMEOUT - 1);
    localparam logic [7:0]    c_NUM_TGT8 = 8'(NUM_TGT);

    logic [1:0]         r_state;
    logic [c_WDW-1:0]   r_wd;
    logic [SW-1:0]      r_sel;
    logic [7:0]         r_out;
    logic [NUM_TGT-1:0] r_strobe;
    logic               r_tstart;
    logic [7:0]         r_tdata;
    logic [7:0]         r_err;

    logic               w_busy;
    logic               w_id_ok;
    logic [NUM_TGT-1:0] w_onehot;
    logic [7:0]         w_rsp [NUM_TGT];

    // Slice the flat response bus into one byte per target.
    genvar k;
    generate
        for (k = 0; k < NUM_TGT; k++) begin : g_rsp
            assign w_rsp[k] = tgt_dout[8*k +: 8];
        end
    endgenerate

    assign w_busy   = (r_state == c_ST_FIRST) || (r_state == c_ST_STREAM);
    assign w_id_ok  = (in_data < c_NUM_TGT8);
    assign w_onehot = {{(NUM_TGT-1){1'b0}}, 1'b1} << r_sel;

    // Frame sequencing, forwarding, watchdog and error counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_wd     <= '0;
            r_sel    <= '0;
            r_out    <= DEFAULT_RSP;
            r_strobe <= '0;
            r_tstart <= 1'b0;
            r_tdata  <= 8'h00;
            r_err    <= 8'h00;
        end else begin
            r_strobe <= '0;
            // The response follows the frame that is open before this edge.
            r_out    <= w_busy ? w_rsp[r_sel] : DEFAULT_RSP;

            if (in_strobe && in_start) begin
                // A start byte always begins a new frame, even mid-frame.
                r_wd <= '0;
                if (w_id_ok) begin
                    r_sel   <= in_data[SW-1:0];
                    r_state <= c_ST_FIRST;
                end else begin
                    r_state <= c_ST_DRAIN;
                    if (r_err != 8'hFF) begin
                        r_err <= r_err + 8'd1;
                    end
                end
            end else if (in_strobe) begin
                r_wd <= '0;
                if (w_busy) begin
                    r_strobe <= w_onehot;
                    r_tdata  <= in_data;
                    r_tstart <= (r_state == c_ST_FIRST);
                    r_state  <= c_ST_STREAM;
                end
            end else if (w_busy) begin
                // No byte this cycle: advance the watchdog or abort the frame.
                if (r_wd == c_WD_LAST) begin
                    r_wd    <= '0;
                    r_state <= c_ST_IDLE;
                    if (r_err != 8'hFF) begin
                        r_err <= r_err + 8'd1;
                    end
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
            end else begin
                r_wd <= '0;
            end
        end
    end

    assign out_data   = r_out;
    assign tgt_strobe = r_strobe;
    assign tgt_start  = r_tstart;
    assign tgt_data   = r_tdata;
    assign busy       = w_busy;
    assign sel        = r_sel;
    assign err_count  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mcu_frame_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcu_frame_router
// Description : Self-checking bench for mcu_frame_router. A frame-level model
//               predicts every output each cycle; directed frames add literal
//               expectations on forwarded bytes and error counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_frame_router;

    localparam int NT = 4;
    localparam int TO = 10;

    logic          clk;
    logic          reset;
    logic          in_strobe;
    logic          in_start;
    logic [7:0]    in_data;
    logic [7:0]    out_data;
    logic [NT-1:0] tgt_strobe;
    logic          tgt_start;
    logic [7:0]    tgt_data;
    logic [NT*8-1:0] tgt_dout;
    logic          busy;
    logic [1:0]    sel;
    logic [7:0]    err_count;

    mcu_frame_router #(
        .NUM_TGT    (NT),
        .TIMEOUT    (TO),
        .DEFAULT_RSP(8'hFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_strobe (in_strobe),
        .in_start  (in_start),
        .in_data   (in_data),
        .out_data  (out_data),
        .tgt_strobe(tgt_strobe),
        .tgt_start (tgt_start),
        .tgt_data  (tgt_data),
        .tgt_dout  (tgt_dout),
        .busy      (busy),
        .sel       (sel),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // A frame is "open" once a valid id arrives; bytes are counted per frame
    // and the watchdog is expressed as the edge distance from the last byte.
    int         cyc      = 0;
    int         m_last   = 0;
    bit         m_open   = 1'b0;
    int         m_tgt    = 0;
    int         m_nbytes = 0;
    logic [7:0]    e_out    = 8'hFF;
    logic [NT-1:0] e_strobe = '0;
    logic          e_start  = 1'b0;
    logic [7:0]    e_data   = 8'h00;
    logic [1:0]    e_sel    = 2'd0;
    int            e_errs   = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_open   = 1'b0;
            m_nbytes = 0;
            m_last   = cyc;
            e_out    = 8'hFF;
            e_strobe = '0;
            e_start  = 1'b0;
            e_data   = 8'h00;
            e_sel    = 2'd0;
            e_errs   = 0;
        end else begin
            e_out    = m_open ? tgt_dout[m_tgt*8 +: 8] : 8'hFF;
            e_strobe = '0;
            if (in_strobe) m_last = cyc;
            if (in_strobe && in_start) begin
                if (int'(in_data) < NT) begin
                    m_open   = 1'b1;
                    m_tgt    = int'(in_data);
                    m_nbytes = 0;
                    e_sel    = in_data[1:0];
                end else begin
                    m_open = 1'b0;
                    e_errs = e_errs + 1;
                end
            end else if (in_strobe) begin
                if (m_open) begin
                    e_strobe = NT'(1 << m_tgt);
                    e_data   = in_data;
                    e_start  = (m_nbytes == 0);
                    m_nbytes = m_nbytes + 1;
                end
            end else if (m_open && (cyc - m_last == TO)) begin
                m_open = 1'b0;
                e_errs = e_errs + 1;
            end
        end
        cyc = cyc + 1;
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_data",   out_data,   e_out);
            chk("tgt_strobe", tgt_strobe, e_strobe);
            chk("tgt_start",  tgt_start,  e_start);
            chk("tgt_data",   tgt_data,   e_data);
            chk("busy",       busy,       m_open);
            chk("sel",        sel,        e_sel);
            chk("err_count",  err_count,  (e_errs > 255) ? 255 : e_errs);
        end
    end

    // Record of forwarded bytes: {tgt_start, tgt_strobe, tgt_data}.
    logic [12:0] log_q [$];
    always @(negedge clk) begin
        if (|tgt_strobe) log_q.push_back({tgt_start, tgt_strobe, tgt_data});
    end

    function automatic logic [12:0] ent(input logic st, input logic [3:0] stb, input logic [7:0] d);
        return {st, stb, d};
    endfunction

    task automatic send(input logic start, input logic [7:0] d);
        @(negedge clk);
        in_strobe = 1'b1;
        in_start  = start;
        in_data   = d;
        @(negedge clk);
        in_strobe = 1'b0;
        in_start  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_strobe = 1'b0;
        in_start  = 1'b0;
        in_data   = 8'h00;
        tgt_dout  = {8'hD3, 8'hC2, 8'hB1, 8'h5C};
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle after reset.
        repeat (100) @(negedge clk);
        chk("idle_out",  out_data,   8'hFF);
        chk("idle_stb",  tgt_strobe, 4'b0000);
        chk("idle_busy", busy,       1'b0);
        chk("idle_err",  err_count,  8'd0);

        // Frame to target 0.
        log_q.delete();
        send(1'b1, 8'h00);
        send(1'b0, 8'h04);
        send(1'b0, 8'h43);
        send(1'b0, 8'h01);
        repeat (2) @(negedge clk);
        chk("t0_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t0_b0", log_q[0], ent(1'b1, 4'b0001, 8'h04));
            chk("t0_b1", log_q[1], ent(1'b0, 4'b0001, 8'h43));
            chk("t0_b2", log_q[2], ent(1'b0, 4'b0001, 8'h01));
        end
        chk("t0_rsp", out_data, 8'h5C);

        // Target 2, then an invalid id drains the rest.
        log_q.delete();
        send(1'b1, 8'h02);
        send(1'b0, 8'hAA);
        send(1'b1, 8'h07);
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        repeat (2) @(negedge clk);
        chk("bad_count", log_q.size(), 1);
        if (log_q.size() == 1) chk("bad_b0", log_q[0], ent(1'b1, 4'b0100, 8'hAA));
        chk("bad_err", err_count, 8'd1);
        chk("bad_rsp", out_data,  8'hFF);

        // Watchdog: one byte then silence.
        log_q.delete();
        send(1'b1, 8'h01);
        send(1'b0, 8'h33);
        repeat (9) @(negedge clk);
        chk("wd_busy9",  busy, 1'b1);
        @(negedge clk);
        chk("wd_busy10", busy, 1'b0);
        chk("wd_err",    err_count, 8'd2);
        log_q.delete();
        send(1'b1, 8'h01);
        send(1'b0, 8'h55);
        repeat (2) @(negedge clk);
        chk("wd_new_cnt", log_q.size(), 1);
        if (log_q.size() == 1) chk("wd_new_b0", log_q[0], ent(1'b1, 4'b0010, 8'h55));

        // New start mid-frame.
        tgt_dout[7:0] = 8'h6D;
        log_q.delete();
        send(1'b1, 8'h01);
        send(1'b0, 8'h10);
        send(1'b0, 8'h20);
        send(1'b1, 8'h03);
        send(1'b0, 8'h77);
        repeat (2) @(negedge clk);
        chk("mid_count", log_q.size(), 3);
        if (log_q.size() == 3) chk("mid_b2", log_q[2], ent(1'b1, 4'b1000, 8'h77));
        chk("mid_err", err_count, 8'd2);
        chk("mid_rsp", out_data,  8'hD3);

        // Error counter saturation.
        log_q.delete();
        for (int i = 0; i < 260; i++) begin
            logic [7:0] id;
            id = 8'h10 + 8'(i % 200);
            send(1'b1, id);
        end
        repeat (2) @(negedge clk);
        chk("sat_err",   err_count, 8'd255);
        chk("sat_count", log_q.size(), 0);

        // Reset in the middle of a stream, with a byte on the same edge.
        send(1'b1, 8'h02);
        send(1'b0, 8'h12);
        send(1'b0, 8'h34);
        @(negedge clk);
        reset     = 1'b1;
        in_strobe = 1'b1;
        in_data   = 8'h99;
        @(negedge clk);
        chk("rst_stb",   tgt_strobe, 4'b0000);
        chk("rst_busy",  busy,       1'b0);
        chk("rst_sel",   sel,        2'd0);
        chk("rst_out",   out_data,   8'hFF);
        chk("rst_err",   err_count,  8'd0);
        chk("rst_data",  tgt_data,   8'h00);
        chk("rst_start", tgt_start,  1'b0);
        reset     = 1'b0;
        in_strobe = 1'b0;

        // Normal operation after reset.
        send(1'b1, 8'h03);
        send(1'b0, 8'hE1);
        repeat (3) @(negedge clk);
        chk("post_busy", busy, 1'b1);
        chk("post_sel",  sel,  2'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mcu_frame_router.md
Name: mcu_frame_router

Overview:
- Sits between the MCU byte-stream receiver and the on-chip MCU targets: system control, HID, OSD and SD/floppy.
- The first byte of every MCU frame (flagged by the start strobe) is a target id. The router re-frames the remaining bytes and forwards them to that one target, then muxes that target's response byte back to the MCU.
- It also aborts stalled frames with a timeout watchdog and counts protocol errors for debug.

Parameters:
- NUM_TGT, 4, number of targets (legal range 2..8); SW = $clog2(NUM_TGT).
- TIMEOUT, 50000, idle cycles between bytes before an open frame is aborted (≥2).
- DEFAULT_RSP, 8'hFF, response byte returned when no valid target is selected.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_strobe  in  1  one-cycle pulse: new MCU byte valid
- in_start  in  1  qualifies in_strobe: byte is the first of a frame
- in_data  in  8  MCU byte
- out_data  out  8  response byte to the MCU
- tgt_strobe  out  NUM_TGT  per-target byte strobe (one-hot or zero)
- tgt_start  out  1  shared; marks the first forwarded byte of a frame
- tgt_data  out  8  shared forwarded byte
- tgt_dout  in  NUM_TGT*8  target responses; target k occupies bits [8k+7:8k]
- busy  out  1  high while a frame is open (FIRST or STREAM)
- sel  out  SW  currently selected target
- err_count  out  8  saturating count of bad ids and timeouts

Behaviour:

Reset values:
- out_data = DEFAULT_RSP; tgt_strobe = 0; tgt_start = 0; tgt_data = 0; busy = 0; sel = 0; err_count = 0.
- State = IDLE; watchdog counter = 0.

States:
- IDLE:
  - in_strobe without in_start is ignored.
- Start byte (accepted in every state, including mid-frame, which silently abandons the old frame without counting an error):
  - If in_data < NUM_TGT: sel <= in_data[SW-1:0]; go to FIRST.
  - Otherwise: go to DRAIN and increment err_count.
  - The start byte itself is never forwarded.
- FIRST:
  - Next in_strobe (non-start): forward the byte with tgt_start = 1; go to STREAM.
- STREAM:
  - Each in_strobe (non-start): forward the byte with tgt_start = 0.
  - The frame stays open until the next start byte or a timeout.
- DRAIN:
  - Non-start bytes are swallowed: no strobes are issued, and out_data = DEFAULT_RSP.

Forwarding timing:
- Registered, 1-cycle latency. The cycle after an accepted in_strobe: tgt_strobe[sel] = 1 for exactly 1 cycle, tgt_data = in_data, and tgt_start as above.
- All other tgt_strobe bits are 0.
- tgt_data and tgt_start hold their values between strobes.

Response:
- out_data is registered every cycle.
- In FIRST/STREAM: out_data = tgt_dout[sel] (1-cycle latency).
- In IDLE/DRAIN: out_data = DEFAULT_RSP.

Watchdog:
- The counter clears on every in_strobe and increments every cycle while in FIRST or STREAM; it is held at 0 in other states.
- When it reaches TIMEOUT-1 with no in_strobe in that cycle: go to IDLE, increment err_count, clear the counter.
- If a start byte arrives in the same cycle the timeout would fire, the start wins and no error is counted.

Other rules:
- err_count saturates at 255 and never wraps. It clears only on reset.
- busy = (state is FIRST or STREAM).
- sel holds its last value in IDLE/DRAIN.
- Reset asserted mid-frame: all outputs return to reset values on the next edge, and no strobe is issued in that cycle.

Test Plan:
- Reset then idle 100 cycles -> out_data = 8'hFF, tgt_strobe = 0, busy = 0, err_count = 0.
- Start byte 8'h00, then bytes 8'h04, 8'h43, 8'h01 -> tgt_strobe = 4'b0001 three times, one cycle after each byte. Data = 04, 43, 01; tgt_start = 1 only on 04. While tgt_dout[7:0] = 8'h5C, out_data = 8'h5C.
- Start byte 8'h02 then 8'hAA; next, start 8'h07 then 8'h11, 8'h22 -> 8'hAA goes to target 2 only. The 11/22 bytes produce no strobes, err_count = 1, and out_data returns to 8'hFF.
- With TIMEOUT = 10: start 8'h01, one byte, then silence -> busy drops after 10 idle cycles and err_count increments. A later start frame to target 1 begins with tgt_start = 1.
- Start 8'h01 plus two bytes, then start 8'h03 plus one byte mid-frame -> the new byte strobes target 3 with tgt_start = 1, and err_count is unchanged.
- 260 invalid-id starts -> err_count stays at 255. Reset mid-STREAM -> no strobe in the following cycle and all outputs at reset values.
